// File: rtl/ofm_ram_responder.sv
// OFM RAM responder: 16-lane line read/write port plus a host dump engine.
// Define OFM_RAM_BYPASS_EN for write-first read/write overlap; read-first when undefined.
module ofm_ram_responder #(
    parameter  int DATA_WIDTH   = 16,
    parameter  int INOUT_WIDTH  = 256,
    parameter  int OFM_RAM_SIZE = 2378675,
    localparam int LANES        = INOUT_WIDTH / DATA_WIDTH,
    localparam int AW           = $clog2(OFM_RAM_SIZE)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ofm_read_en,
    input  logic [AW-1:0]          ofm_addr_a,
    output logic [INOUT_WIDTH-1:0] ofm_data_in,
    input  logic                   write_out_ofm_en,
    input  logic [AW-1:0]          ofm_addr_b,
    input  logic [INOUT_WIDTH-1:0] ofm_data_out,
    input  logic [4:0]             write_ofm_size,
    input  logic                   dump_start,
    input  logic [AW-1:0]          dump_base,
    input  logic [AW-1:0]          dump_len,
    output logic                   dump_valid,
    input  logic                   dump_ready,
    output logic [DATA_WIDTH-1:0]  dump_data,
    output logic                   dump_busy,
    output logic                   dump_done
);

    // One extra address bit so lane offsets and the dump pointer never wrap back to 0.
    localparam int          EW     = AW + 1;
    localparam logic [EW-1:0] SIZE_W = EW'(OFM_RAM_SIZE);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PRESENT} dump_state_t;

    logic [DATA_WIDTH-1:0]  mem [OFM_RAM_SIZE];
    logic [EW-1:0]          rd_addr [LANES];
    logic [EW-1:0]          wr_addr [LANES];
    logic [LANES-1:0]       wr_lane_en;
    logic [4:0]             wr_count;
    logic [INOUT_WIDTH-1:0] rd_line;

    dump_state_t            state, next_state;
    logic [EW-1:0]          ptr;
    logic [AW-1:0]          rem;
    logic [DATA_WIDTH-1:0]  dump_rd;

    assign wr_count = (write_ofm_size > 5'(LANES)) ? 5'(LANES) : write_ofm_size;

    always_comb begin
        // NOTE: every variable written in always_comb gets a value on every path, so no latch is inferred.
        for (int i = 0; i < LANES; i++) begin
            rd_addr[i]    = {1'b0, ofm_addr_a} + EW'(i);
            wr_addr[i]    = {1'b0, ofm_addr_b} + EW'(i);
            // A write sampled while reset is asserted is dropped.
            wr_lane_en[i] = rst_n && write_out_ofm_en && (5'(i) < wr_count) && (wr_addr[i] < SIZE_W);
        end
    end

    always_comb begin
        rd_line = '0;
        for (int i = 0; i < LANES; i++) begin
            if (rd_addr[i] < SIZE_W) begin
                rd_line[i*DATA_WIDTH +: DATA_WIDTH] = mem[rd_addr[i][AW-1:0]];
`ifdef OFM_RAM_BYPASS_EN
                for (int j = 0; j < LANES; j++) begin
                    if (wr_lane_en[j] && (wr_addr[j] == rd_addr[i]))
                        rd_line[i*DATA_WIDTH +: DATA_WIDTH] = ofm_data_out[j*DATA_WIDTH +: DATA_WIDTH];
                end
`endif
            end
        end
    end

    // NOTE: the storage array has no reset; contents survive reset and only control/output state is cleared.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_lane_en[i])
                mem[wr_addr[i][AW-1:0]] <= ofm_data_out[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ofm_data_in <= '0;
        else if (ofm_read_en)
            ofm_data_in <= rd_line;
    end

    // Dump port reads the array directly, so it always sees pre-write contents.
    assign dump_rd = (ptr < SIZE_W) ? mem[ptr[AW-1:0]] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:    if (dump_start && (dump_len != '0)) next_state = S_FETCH;
            S_FETCH:   next_state = S_PRESENT;
            S_PRESENT: if (dump_ready) next_state = (rem == AW'(1)) ? S_IDLE : S_FETCH;
            default:   next_state = S_IDLE;
        endcase
    end

    always_comb begin
        dump_valid = (state == S_PRESENT);
        dump_busy  = (state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            rem       <= '0;
            dump_data <= '0;
            dump_done <= 1'b0;
        end else begin
            dump_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (dump_start) begin
                        ptr       <= {1'b0, dump_base};
                        rem       <= dump_len;
                        dump_done <= (dump_len == '0);
                    end
                end
                S_FETCH:   dump_data <= dump_rd;
                S_PRESENT: begin
                    if (dump_ready) begin
                        ptr       <= ptr + EW'(1);
                        rem       <= rem - AW'(1);
                        dump_done <= (rem == AW'(1));
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ofm_ram_responder.sv
// Scoreboard bench for ofm_ram_responder: random line traffic and dumps checked against
// an element-level memory model; honours OFM_RAM_BYPASS_EN for read/write overlap.
module tb_ofm_ram_responder;

    localparam int SIZE  = 2378675;
    localparam int AW    = $clog2(SIZE);
    localparam int LANES = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ofm_read_en;
    logic [AW-1:0] ofm_addr_a;
    logic [255:0] ofm_data_in;
    logic         write_out_ofm_en;
    logic [AW-1:0] ofm_addr_b;
    logic [255:0] ofm_data_out;
    logic [4:0]   write_ofm_size;
    logic         dump_start;
    logic [AW-1:0] dump_base;
    logic [AW-1:0] dump_len;
    logic         dump_valid;
    logic         dump_ready;
    logic [15:0]  dump_data;
    logic         dump_busy;
    logic         dump_done;

    ofm_ram_responder dut (
        .clk(clk), .rst_n(rst_n),
        .ofm_read_en(ofm_read_en), .ofm_addr_a(ofm_addr_a), .ofm_data_in(ofm_data_in),
        .write_out_ofm_en(write_out_ofm_en), .ofm_addr_b(ofm_addr_b),
        .ofm_data_out(ofm_data_out), .write_ofm_size(write_ofm_size),
        .dump_start(dump_start), .dump_base(dump_base), .dump_len(dump_len),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
        .dump_busy(dump_busy), .dump_done(dump_done)
    );

    always #5 clk = ~clk;

    typedef struct { logic [255:0] data; logic [255:0] mask; } rd_exp_t;
    typedef struct { logic [15:0] data; bit known; } dump_exp_t;

    int        tests = 0;
    int        fails = 0;
    logic [15:0] model [int unsigned];
    rd_exp_t   rd_q[$];
    dump_exp_t dump_q[$];
    rd_exp_t   last_exp;
    logic      rd_seen;
    bit        dump_active = 0;
    int        beats_left = 0;
    bit        done_due = 0;
    bit        prev_stall = 0;
    bit        ready_rand = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp,
                         input logic [255:0] mask);
        tests++;
        if (((act ^ exp) & mask) != '0) begin
            fails++;
            $display("FAIL %s: got %h expected %h (mask %h)", name, act, exp, mask);
        end
    endtask

    task automatic flag_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: event occurred with no expectation pending", name);
    endtask

    // Element-level reference model: a sparse array; unwritten in-range cells are unknown.
    function automatic void model_write(input int unsigned addr, input logic [255:0] data, input int size);
        int n;
        n = (size > LANES) ? LANES : size;
        for (int i = 0; i < n; i++)
            if (addr + i < SIZE) model[addr + i] = data[i*16 +: 16];
    endfunction

    function automatic void model_read(input int unsigned addr, output logic [255:0] line,
                                       output logic [255:0] mask);
        line = '0;
        mask = '0;
        for (int i = 0; i < LANES; i++) begin
            if (addr + i >= SIZE) begin
                mask[i*16 +: 16] = 16'hFFFF;
            end else if (model.exists(addr + i)) begin
                line[i*16 +: 16] = model[addr + i];
                mask[i*16 +: 16] = 16'hFFFF;
            end
        end
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic int unsigned pick_addr();
        if ($urandom_range(0, 3) == 0) return $urandom_range(SIZE - 40, SIZE - 1);
        return $urandom_range(0, 999);
    endfunction

    // One bus cycle; called at posedge+1, returns at the next posedge+1.
    task automatic drive(input bit rd, input int unsigned ra, input bit wr, input int unsigned wa,
                         input logic [255:0] wd, input int sz);
        rd_exp_t e;
        ofm_read_en      = rd;
        ofm_addr_a       = AW'(ra);
        write_out_ofm_en = wr;
        ofm_addr_b       = AW'(wa);
        ofm_data_out     = wd;
        write_ofm_size   = 5'(sz);
`ifdef OFM_RAM_BYPASS_EN
        if (wr) model_write(wa, wd, sz);
        if (rd) begin model_read(ra, e.data, e.mask); rd_q.push_back(e); end
`else
        if (rd) begin model_read(ra, e.data, e.mask); rd_q.push_back(e); end
        if (wr) model_write(wa, wd, sz);
`endif
        @(posedge clk); #1;
        ofm_read_en      = 1'b0;
        write_out_ofm_en = 1'b0;
    endtask

    task automatic run_dump(input int unsigned base, input int unsigned len, input bit poke);
        dump_exp_t e;
        int c;
        int budget;
        for (int unsigned k = 0; k < len; k++) begin
            e.known = 1'b1;
            e.data  = '0;
            if (base + k < SIZE) begin
                if (model.exists(base + k)) e.data = model[base + k];
                else e.known = 1'b0;
            end
            dump_q.push_back(e);
        end
        beats_left = len;
        dump_start = 1'b1;
        dump_base  = AW'(base);
        dump_len   = AW'(len);
        @(posedge clk); #1;
        dump_start = 1'b0;
        c = 0;
        budget = 8 * len + 20;
        while ((dump_active || dump_q.size() != 0) && c < budget) begin
            dump_start = poke && (c == 3);
            dump_len   = '0;
            @(posedge clk); #1;
            c++;
        end
        dump_start = 1'b0;
        if (c >= budget) flag_fail("dump_timeout");
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Read monitor: a line is due the cycle after each accepted read, else the output holds.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_seen <= 1'b0;
        else        rd_seen <= ofm_read_en;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_seen) begin
                if (rd_q.size() == 0) flag_fail("rd_unexpected");
                else begin
                    last_exp = rd_q.pop_front();
                    check("rd_line", ofm_data_in, last_exp.data, last_exp.mask);
                end
            end else begin
                check("rd_hold", ofm_data_in, last_exp.data, last_exp.mask);
            end
        end
    end

    // Dump monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            check("dump_done", 256'(dump_done), 256'(done_due), 256'd1);
            check("dump_busy", 256'(dump_busy), 256'(dump_active), 256'd1);
            done_due = 1'b0;
            if (prev_stall) check("valid_held", 256'(dump_valid), 256'd1, 256'd1);
            prev_stall = dump_valid && !dump_ready;
            if (dump_start && !dump_active) begin
                if (dump_len == '0) done_due = 1'b1;
                else dump_active = 1'b1;
            end
            if (dump_valid) begin
                if (dump_q.size() == 0) flag_fail("dump_unexpected");
                else begin
                    check("dump_data", 256'(dump_data), 256'(dump_q[0].data),
                          dump_q[0].known ? 256'hFFFF : 256'h0);
                    if (dump_ready) begin
                        void'(dump_q.pop_front());
                        beats_left--;
                        if (beats_left == 0) begin
                            done_due    = 1'b1;
                            dump_active = 1'b0;
                        end
                    end
                end
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (ready_rand) dump_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] d;
        rst_n = 1'b0;
        ofm_read_en = 1'b0; ofm_addr_a = '0; write_out_ofm_en = 1'b0; ofm_addr_b = '0;
        ofm_data_out = '0; write_ofm_size = '0; dump_start = 1'b0; dump_base = '0;
        dump_len = '0; dump_ready = 1'b0;
        last_exp.data = '0;
        last_exp.mask = '1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ofm_data_in", ofm_data_in, '0, '1);
        check("rst_dump_valid", 256'(dump_valid), '0, 256'd1);
        check("rst_dump_data", 256'(dump_data), '0, 256'hFFFF);
        check("rst_dump_busy", 256'(dump_busy), '0, 256'd1);
        check("rst_dump_done", 256'(dump_done), '0, 256'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        ready_rand = 1'b1;

        // Prefill the regions exercised below.
        for (int a = 0; a < 1024; a += 16) drive(0, 0, 1, a, rand_line(), 16);
        for (int a = SIZE - 48; a < SIZE; a += 16) drive(0, 0, 1, a, rand_line(), 16);

        // Full line write then read back.
        for (int i = 0; i < LANES; i++) d[i*16 +: 16] = 16'(i + 1);
        drive(0, 0, 1, 100, d, 16);
        drive(1, 100, 0, 0, '0, 0);
        drive(0, 0, 0, 0, '0, 0);

        // Dump with random backpressure, then zero-length dump.
        run_dump(100, 5, 0);
        run_dump(50, 0, 0);

        // Partial writes: size 3, size 0, oversize.
        drive(0, 0, 1, 200, rand_line(), 3);
        drive(1, 200, 0, 0, '0, 0);
        drive(0, 0, 1, 200, rand_line(), 0);
        drive(1, 200, 0, 0, '0, 0);
        drive(0, 0, 1, 200, rand_line(), 20);
        drive(1, 200, 0, 0, '0, 0);

        // Top-of-memory boundary and no aliasing to address 0.
        drive(1, SIZE - 4, 0, 0, '0, 0);
        drive(0, 0, 1, SIZE - 4, rand_line(), 16);
        drive(1, SIZE - 4, 0, 0, '0, 0);
        drive(1, 0, 0, 0, '0, 0);

        // Same-cycle overlap.
        d = '0; d[15:0] = 16'h5555;
        drive(0, 0, 1, 300, d, 1);
        d[15:0] = 16'hAAAA;
        drive(1, 300, 1, 300, d, 1);
        drive(0, 0, 0, 0, '0, 0);

        // Random traffic with frequent overlap.
        for (int k = 0; k < 400; k++) begin
            int unsigned ra;
            int unsigned wa;
            ra = pick_addr();
            wa = ($urandom_range(0, 3) == 0) ? ra + $urandom_range(0, 8) : pick_addr();
            drive(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), wa, rand_line(),
                  $urandom_range(0, 31));
        end
        drive(0, 0, 0, 0, '0, 0);

        // More dumps: random region, top edge, and a start pulse while busy.
        run_dump($urandom_range(0, 900), $urandom_range(1, 12), 0);
        run_dump(SIZE - 3, 6, 0);
        run_dump(10, 8, 1);

        // Reset in the middle of a dump.
        run_dump_abort();

        run_dump(100, 3, 0);
        drive(1, 100, 0, 0, '0, 0);
        drive(0, 0, 0, 0, '0, 0);
        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    task automatic run_dump_abort();
        dump_start = 1'b1;
        dump_base  = AW'(0);
        dump_len   = AW'(30);
        for (int k = 0; k < 30; k++) dump_q.push_back('{data: 16'h0, known: 1'b0});
        beats_left = 30;
        @(posedge clk); #1;
        dump_start = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_dump_valid", 256'(dump_valid), '0, 256'd1);
        check("abort_dump_busy", 256'(dump_busy), '0, 256'd1);
        check("abort_dump_data", 256'(dump_data), '0, 256'hFFFF);
        check("abort_dump_done", 256'(dump_done), '0, 256'd1);
        check("abort_ofm_data_in", ofm_data_in, '0, '1);
        dump_q.delete();
        rd_q.delete();
        dump_active   = 1'b0;
        beats_left    = 0;
        done_due      = 1'b0;
        prev_stall    = 1'b0;
        last_exp.data = '0;
        last_exp.mask = '1;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

endmodule

// File: doc/ofm_ram_responder.md
# ofm_ram_responder

Memory-side responder for the accelerator's OFM RAM interface. It serves the 256-bit line reads issued on `ofm_read_en`/`ofm_addr_a` and absorbs the partial-line writes issued on `write_out_ofm_en`/`ofm_addr_b`/`write_ofm_size`. It also provides a host dump engine that streams a region of OFM storage out one element per beat after `done_CNN`. It sits beside `yolov3_tiny` at SoC level, in place of the external OFM RAM.

## Interface
- `DATA_WIDTH`, 16: bits per element.
- `INOUT_WIDTH`, 256: line width; `LANES = INOUT_WIDTH/DATA_WIDTH` (16).
- `OFM_RAM_SIZE`, 2378675: storage depth in elements; `AW = $clog2(OFM_RAM_SIZE)`.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ofm_read_en`  in  1  line read request.
- `ofm_addr_a`  in  AW  element address of lane 0 for the read.
- `ofm_data_in`  out  INOUT_WIDTH  read line; lane i is bits [i*DATA_WIDTH +: DATA_WIDTH].
- `write_out_ofm_en`  in  1  line write request.
- `ofm_addr_b`  in  AW  element address of lane 0 for the write.
- `ofm_data_out`  in  INOUT_WIDTH  write line.
- `write_ofm_size`  in  5  number of valid lanes, starting from lane 0.
- `dump_start`  in  1  one-cycle pulse that starts a dump.
- `dump_base`  in  AW  first element to dump.
- `dump_len`  in  AW  number of elements to dump.
- `dump_valid`  out  1  dump beat valid.
- `dump_ready`  in  1  host accepts the beat.
- `dump_data`  out  DATA_WIDTH  dump element.
- `dump_busy`  out  1  dump in progress.
- `dump_done`  out  1  one-cycle pulse when the last beat is accepted.

## Operation
- Storage: `OFM_RAM_SIZE` elements of `DATA_WIDTH` bits. Contents are not cleared by reset.
- Read: when `ofm_read_en`=1, lane i returns element `ofm_addr_a+i`. Lanes whose address is at or above `OFM_RAM_SIZE` return 0.
- Write: when `write_out_ofm_en`=1, lanes 0..n-1 are written to `ofm_addr_b+i`, where n = min(`write_ofm_size`, LANES).
  - `write_ofm_size`=0 writes nothing.
  - Lanes whose address is out of range are dropped silently.
- Read and write may occur in the same cycle. Overlap behaviour is set by the configuration macro.
- Dump FSM, states IDLE, FETCH, PRESENT:
  - IDLE: on `dump_start`, latch `ptr=dump_base` and `rem=dump_len`.
    - If `rem`=0, pulse `dump_done` and stay in IDLE.
    - Otherwise go to FETCH.
  - FETCH: read element `ptr` (0 if out of range) into `dump_data`, then go to PRESENT.
  - PRESENT: `dump_valid`=1. On `dump_ready`, decrement `rem` and increment `ptr`.
    - If `rem` was 1, pulse `dump_done` and go to IDLE.
    - Otherwise go to FETCH.
  - `dump_start` is ignored outside IDLE.
  - The dump read port is independent of the CNN ports; there is no arbitration and no stall.
  - `ptr` does not wrap; it saturates in effect because out-of-range addresses read 0.
- `dump_busy` = (state != IDLE).

## Timing
- Read latency is 1 cycle: `ofm_data_in` is registered and updates on the edge after `ofm_read_en`=1. It holds its last value while `ofm_read_en`=0.
- A write is visible to reads issued from the next cycle onward.
- Dump throughput is one element per 2 cycles.
  - `dump_data` is stable while `dump_valid`=1 and `dump_ready`=0.
  - `dump_valid` never drops without a handshake.
- Reset values: `ofm_data_in`=0, `dump_valid`=0, `dump_data`=0, `dump_busy`=0, `dump_done`=0, FSM in IDLE.
- Reset asserted mid-dump aborts the dump immediately with no `dump_done`. Memory writes in flight on that edge are dropped.

## Configuration
- `OFM_RAM_BYPASS_EN` defined: a read overlapping a same-cycle write returns the newly written data for the overlapping lanes (write-first).
- Not defined: the read returns the pre-write contents (read-first).
- The dump port is always read-first relative to same-cycle writes.

## Test plan
- Write addr_b=100, size=16, lanes = 0x0001..0x0010, then read addr_a=100 → next cycle `ofm_data_in` lanes = 0x0001..0x0010.
- Write addr_b=200, size=3, then read addr_a=200 → lanes 0-2 updated, lanes 3-15 unchanged. Repeat with size=0 → no change; size=20 → behaves as 16.
- Read addr_a=`OFM_RAM_SIZE`-4 → lanes 0-3 hold data, lanes 4-15 = 0. Write at the same address → only 4 elements are stored and nothing aliases to address 0.
- Same-cycle write addr_b=300 (0xAAAA) and read addr_a=300, with previous content 0x5555 → lane 0 = 0xAAAA with `OFM_RAM_BYPASS_EN`, 0x5555 without.
- Dump base=100, len=5, with `dump_ready` toggled randomly → 5 beats 0x0001..0x0005 in order, data stable under backpressure, `dump_done` on the 5th accept, `dump_busy` falls the same cycle.
- Dump len=0 → `dump_done` pulses 1 cycle after `dump_start` with no `dump_valid`. Assert `rst_n`=0 mid-dump → all dump outputs 0 asynchronously and no `dump_done`.
